comp_step_engine: RTL and testbench
===================================

// Module: comp_step_engine
// PURPOSE
//   Parametrised 1-D ring cellular-automaton coprocessor; next generation of the CPU's COMP state unit.
//   Holds STATE_BYTES*8 one-bit cells. Executes LOAD, STEP and COMPARE commands against a flattened ROM bus.
//   STEP runs a programmable number of generations over multiple cycles under a valid/ready handshake.
//   Sits beside the CPU core; the CPU issues opcodes as commands and stalls on busy.
// PARAMETERS
//   STATE_BYTES  16  bytes of automaton state; cells N = 8*STATE_BYTES, cell i = state[i/8][i%8]
//   ROM_BYTES    82  width of the rom bus in bytes
//   ADDR_W       8   width of cmd_addr (byte offset into rom)
//   CNT_W        8   width of cmd_count (generations per STEP)
// PORTS
//   clk          in   1                clock, rising edge
//   rst          in   1                asynchronous, active-high reset
//   rom          in   8*ROM_BYTES      flattened ROM, byte k = rom[8k +: 8]
//   cmd_valid    in   1                command present
//   cmd_ready    out  1                engine can accept; equals !busy
//   cmd_op       in   2                0 LOAD, 1 STEP, 2 COMPARE, 3 reserved
//   cmd_rule     in   1                STEP rule: 0 = L^(C&R), 1 = L^R
//   cmd_addr     in   ADDR_W           ROM byte offset for LOAD/COMPARE
//   cmd_count    in   CNT_W            generations for STEP
//   busy         out  1                multi-cycle STEP in progress
//   done         out  1                one-cycle pulse on command completion
//   match        out  1                result of last COMPARE (sticky until next COMPARE)
//   err          out  1                one-cycle pulse with done for reserved op
//   state_out    out  8*STATE_BYTES    current cell state, byte j = state[j]
// BEHAVIOUR
//   Reset (async, any time incl. mid-STEP): state=0, busy=0, done=0, match=0, err=0, counters=0; the pending STEP is dropped.
//   Accept: cmd_valid & cmd_ready at rising edge k; all cmd_* fields sampled at edge k only.
//   ROM read: byte (cmd_addr+j) for j in 0..STATE_BYTES-1; use an index wider than ADDR_W (no wrap); index >= ROM_BYTES reads 0x00.
//   LOAD: at edge k, state[j] <= rom byte (cmd_addr+j); done=1 for the cycle after k; busy stays 0.
//   COMPARE: at edge k, match <= (state == ROM window at cmd_addr), all STATE_BYTES bytes; done pulses after k.
//   Reserved op 3: no state change; done=1 and err=1 for the cycle after k.
//   STEP, count n=0: no-op; done pulses after k; busy stays 0.
//   STEP, n>=1: FSM IDLE->RUN at edge k, busy=1; one generation per edge k+1..k+n; at edge k+n RUN->IDLE,
//     busy=0, done=1. Total latency n+1 cycles from acceptance to done.
//   Generation: ring neighbours L=cell[(i-1) mod N], C=cell[i], R=cell[(i+1) mod N]; all cells update
//     simultaneously from the previous generation (no in-place ripple). Cell 0's L = cell N-1; cell N-1's R = cell 0.
//   Rule 0: next = L ^ (C & R), i.e. a+b*c truncated to 1 bit. Rule 1: next = L ^ R. Rule latched at acceptance.
//   Remaining-count register is CNT_W bits; decrements once per generation; RUN exits when it reaches 1 -> 0.
//   cmd_valid while busy: ignored (cmd_ready=0); the command holds off with no side effects.
//   Back-to-back: a new command is accepted on the same edge done is raised (cmd_ready=1 in that cycle).
//   state_out and match are registered; they change only at the edges defined above.
// TESTING
//   LOAD rom bytes 0..15 = 0x00..0x0F, cmd_addr=0 -> state_out byte j = j; done pulses once; busy never 1.
//   LOAD state byte0=0x01 rest 0; STEP rule 0, n=1 -> byte0=0x02, rest 0; busy 1 cycle; done on the next cycle.
//   Same seed, STEP rule 1, n=1 -> byte0=0x02, byte15=0x80 (ring wrap cell 127); n=0 -> state unchanged, done only.
//   LOAD at cmd_addr=70 with ROM_BYTES=82 -> bytes 12..15 read 0x00; COMPARE at 70 -> match=1; after STEP -> match=0.
//   STEP n=255: assert cmd_valid during RUN -> ignored; done at cycle 256 after accept; command accepted on that edge.
//   Assert rst mid-STEP (n=10, after 4 generations) -> all outputs 0 immediately; after release, state_out=0 and busy=0.

Source files
------------

// File: rtl/comp_step_engine.sv
// Ring cellular-automaton coprocessor: LOAD / STEP / COMPARE against a flattened ROM bus.
// Latency: LOAD/COMPARE/reserved/STEP(0) complete one cycle after accept; STEP(n>=1) completes n+1 cycles after accept.
// Backpressure: cmd_ready is low while a STEP is running; commands offered then are held off with no side effects.
module comp_step_engine #(
    parameter int STATE_BYTES = 16,
    parameter int ROM_BYTES   = 82,
    parameter int ADDR_W      = 8,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*ROM_BYTES-1:0]   rom,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic                     cmd_rule,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [CNT_W-1:0]         cmd_count,
    output logic                     busy,
    output logic                     done,
    output logic                     match,
    output logic                     err,
    output logic [8*STATE_BYTES-1:0] state_out
);
    localparam int N = 8 * STATE_BYTES;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_STEP    = 2'd1;
    localparam logic [1:0] OP_COMPARE = 2'd2;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [N-1:0]     cells_q, cells_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rule_q, rule_d;
    logic             match_q, match_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [N-1:0]     window;
    logic [N-1:0]     next_gen;
    logic             accept;

    assign cmd_ready = (fsm_q == IDLE);
    assign busy      = (fsm_q == RUN);
    assign accept    = cmd_valid & cmd_ready;
    assign done      = done_q;
    assign err       = err_q;
    assign match     = match_q;
    assign state_out = cells_q;

    // ROM window at cmd_addr; the index is 32 bits wide so it never wraps, and bytes past the ROM read as zero.
    always_comb begin : rom_window
        logic [31:0] idx;
        window = '0;
        for (int j = 0; j < STATE_BYTES; j++) begin
            idx = 32'(cmd_addr) + 32'(j);
            if (idx < 32'(ROM_BYTES)) begin
                window[8*j +: 8] = rom[idx*8 +: 8];
            end
        end
    end

    // One generation of the ring automaton, computed entirely from the current registered cells.
    always_comb begin
        next_gen = '0;
        for (int i = 0; i < N; i++) begin
            if (rule_q) begin
                next_gen[i] = cells_q[(i + N - 1) % N] ^ cells_q[(i + 1) % N];
            end else begin
                next_gen[i] = cells_q[(i + N - 1) % N] ^ (cells_q[i] & cells_q[(i + 1) % N]);
            end
        end
    end

    // Command decode and STEP sequencing.
    always_comb begin
        fsm_d   = fsm_q;
        cells_d = cells_q;
        cnt_d   = cnt_q;
        rule_d  = rule_q;
        match_d = match_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_LOAD: begin
                            cells_d = window;
                            done_d  = 1'b1;
                        end
                        OP_STEP: begin
                            if (cmd_count == '0) begin
                                done_d = 1'b1;
                            end else begin
                                fsm_d  = RUN;
                                cnt_d  = cmd_count;
                                rule_d = cmd_rule;
                            end
                        end
                        OP_COMPARE: begin
                            match_d = (cells_q == window);
                            done_d  = 1'b1;
                        end
                        default: begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            RUN: begin
                cells_d = next_gen;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    fsm_d  = IDLE;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers; reset drops any STEP in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            cells_q <= '0;
            cnt_q   <= '0;
            rule_q  <= 1'b0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cells_q <= cells_d;
            cnt_q   <= cnt_d;
            rule_q  <= rule_d;
            match_q <= match_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_comp_step_engine.sv
// Directed bench for comp_step_engine: LOAD, STEP rules, COMPARE, reserved op, ROM bounds, hold-off and reset.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Each check is an immediate assertion that counts failures for the summary line.
module tb_comp_step_engine;
    localparam int SB = 16;
    localparam int RB = 82;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [8*RB-1:0]   rom;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic              cmd_rule = 1'b0;
    logic [7:0]        cmd_addr = 8'd0;
    logic [7:0]        cmd_count = 8'd0;
    logic              busy, done, match, err;
    logic [8*SB-1:0]   state_out;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [127:0] RAMP   = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] SEED   = 128'h1;
    localparam logic [127:0] WIN70  = 128'h00000000ABAAA9A8A7A6A5A4A3A2A1A0;

    comp_step_engine #(.STATE_BYTES(SB), .ROM_BYTES(RB), .ADDR_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rom(rom),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rule(cmd_rule),
        .cmd_addr(cmd_addr), .cmd_count(cmd_count),
        .busy(busy), .done(done), .match(match), .err(err), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for exactly one edge (engine must be idle).
    task automatic issue(input logic [1:0] op, input logic rule, input logic [7:0] addr, input logic [7:0] cnt);
        cmd_op    = op;
        cmd_rule  = rule;
        cmd_addr  = addr;
        cmd_count = cnt;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int c;
        int busy_cnt;
        logic changed;

        rom = '0;
        for (int k = 0; k < 16; k++) rom[8*k +: 8] = 8'(k);
        rom[8*16 +: 8] = 8'h01;
        for (int m = 0; m < 12; m++) rom[8*(70+m) +: 8] = 8'hA0 + 8'(m);

        // Reset state while reset is held
        #2;
        chk("rst_state", state_out, '0);
        chk("rst_flags", {busy, done, match, err}, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", cmd_ready, 1'b1);

        // LOAD ramp from address 0
        issue(2'd0, 1'b0, 8'd0, 8'd0);
        chk("load0_state", state_out, RAMP);
        chk("load0_done_busy", {done, busy, err}, 3'b100);
        tick();
        chk("load0_done_pulse", done, 1'b0);

        // COMPARE against the same window
        issue(2'd2, 1'b0, 8'd0, 8'd0);
        chk("cmp0_match", {done, match}, 2'b11);

        // Single cell seed, rule 0, one generation
        issue(2'd0, 1'b0, 8'd16, 8'd0);
        chk("seed_state", state_out, SEED);
        issue(2'd1, 1'b0, 8'd0, 8'd1);
        chk("r0_run", {busy, done, cmd_ready}, 3'b100);
        chk("r0_hold", state_out, SEED);
        tick();
        chk("r0_done", {busy, done, cmd_ready}, 3'b011);
        chk("r0_state", state_out, 128'h2);

        // Same seed, rule 1 wraps to cell 127
        issue(2'd0, 1'b0, 8'd16, 8'd0);
        issue(2'd1, 1'b1, 8'd0, 8'd1);
        tick();
        chk("r1_state", state_out, (128'h1 << 127) | 128'h2);

        // STEP with count 0 is a no-op that still completes
        issue(2'd1, 1'b0, 8'd0, 8'd0);
        chk("n0_flags", {busy, done, err}, 3'b010);
        chk("n0_state", state_out, (128'h1 << 127) | 128'h2);

        // Reserved opcode
        issue(2'd3, 1'b0, 8'd0, 8'd0);
        chk("rsv_flags", {done, err, busy}, 3'b110);
        chk("rsv_state", state_out, (128'h1 << 127) | 128'h2);
        tick();
        chk("rsv_pulse", {done, err}, 2'b00);

        // Window running past the end of the ROM
        issue(2'd0, 1'b0, 8'd70, 8'd0);
        chk("load70_state", state_out, WIN70);
        issue(2'd2, 1'b0, 8'd70, 8'd0);
        chk("cmp70_match", match, 1'b1);
        issue(2'd1, 1'b0, 8'd0, 8'd1);
        tick();
        chk("match_sticky", match, 1'b1);
        issue(2'd2, 1'b0, 8'd70, 8'd0);
        chk("cmp70_after_step", {done, match}, 2'b10);

        // High address must not wrap into low ROM bytes
        issue(2'd0, 1'b0, 8'd250, 8'd0);
        chk("load250_state", state_out, '0);

        // Long STEP on an all-zero ring while a LOAD is held off
        issue(2'd1, 1'b0, 8'd0, 8'd255);
        chk("long_busy", {busy, cmd_ready}, 2'b10);
        cmd_op    = 2'd0;
        cmd_addr  = 8'd0;
        cmd_valid = 1'b1;
        c         = 0;
        busy_cnt  = 0;
        changed   = 1'b0;
        while (!done && c < 300) begin
            tick();
            c++;
            if (busy) busy_cnt++;
            if (state_out !== '0) changed = 1'b1;
        end
        chk("long_latency", 128'(c), 128'd255);
        chk("long_busy_cycles", 128'(busy_cnt), 128'd254);
        chk("long_holdoff", changed, 1'b0);
        chk("long_done_ready", {done, busy, cmd_ready}, 3'b101);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_state", state_out, RAMP);
        chk("b2b_done", done, 1'b1);

        // Reset in the middle of a STEP
        issue(2'd2, 1'b0, 8'd0, 8'd0);
        chk("pre_rst_match", match, 1'b1);
        issue(2'd1, 1'b1, 8'd0, 8'd10);
        for (int g = 0; g < 4; g++) tick();
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", state_out, '0);
        chk("mid_rst_flags", {busy, done, match, err}, 4'b0000);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_state", state_out, '0);
        chk("post_rst_flags", {busy, done, cmd_ready}, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
